// File: rtl/fila_cmd_front.sv
// ============================================================================
//  Module   : fila_cmd_front
//  Function : push-button command front-end for an 8-entry byte queue
//             (sync, debounce, edge detect, legality-checked strobes)
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fila_cmd_front #(
    parameter int WIDTH           = 8,
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 200
) (
    input  logic             clk_10KHz,
    input  logic             reset,
    input  logic             btn_enq_raw,
    input  logic             btn_deq_raw,
    input  logic [WIDTH-1:0] sw_data,
    input  logic [7:0]       len_in,
    output logic [WIDTH-1:0] data_out,
    output logic             enqueue_out,
    output logic             dequeue_out,
    output logic             reject_out,
    output logic             full_out,
    output logic             empty_out
);

    localparam int                 C_CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]         C_DEPTH    = 8'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENQ  = 2'd1,
        S_DEQ  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    // Channel 0 is enqueue, channel 1 is dequeue.
    logic [1:0] w_raw;
    logic [1:0] w_rise;

    assign w_raw = {btn_deq_raw, btn_enq_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic               r_sync1;
            logic               r_sync2;
            logic               r_level;
            logic               r_level_d;
            logic [C_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk_10KHz or posedge reset) begin
                if (reset) begin
                    r_sync1   <= 1'b0;
                    r_sync2   <= 1'b0;
                    r_level   <= 1'b0;
                    r_level_d <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_sync1   <= w_raw[gi];
                    r_sync2   <= r_sync1;
                    r_level_d <= r_level;
                    if (r_sync2 == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_level <= ~r_level;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_rise[gi] = r_level & ~r_level_d;
        end
    endgenerate

    state_t r_state;
    state_t w_state_next;
    logic   r_pend_enq;
    logic   r_pend_deq;
    logic   w_clr_enq;
    logic   w_clr_deq;
    logic   w_reject;
    logic   w_load;
    logic   w_full;
    logic   w_empty;

    assign w_full  = (len_in >= C_DEPTH);
    assign w_empty = (len_in == 8'd0);

    always_comb begin
        w_state_next = r_state;
        w_clr_enq    = 1'b0;
        w_clr_deq    = 1'b0;
        w_reject     = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_enq) begin
                    w_clr_enq = 1'b1;
                    if (!w_full) begin
                        w_load       = 1'b1;
                        w_state_next = S_ENQ;
                    end else begin
                        w_reject = 1'b1;
                    end
                end else if (r_pend_deq) begin
                    w_clr_deq = 1'b1;
                    if (!w_empty) begin
                        w_state_next = S_DEQ;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_ENQ:   w_state_next = S_HOLD;
            S_DEQ:   w_state_next = S_HOLD;
            S_HOLD:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // A fresh edge arriving on the same cycle the request is consumed survives.
    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pend_enq  <= 1'b0;
            r_pend_deq  <= 1'b0;
            data_out    <= '0;
            enqueue_out <= 1'b0;
            dequeue_out <= 1'b0;
            reject_out  <= 1'b0;
            full_out    <= 1'b0;
            empty_out   <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_pend_enq  <= (r_pend_enq & ~w_clr_enq) | w_rise[0];
            r_pend_deq  <= (r_pend_deq & ~w_clr_deq) | w_rise[1];
            if (w_load) begin
                data_out <= sw_data;
            end
            enqueue_out <= (w_state_next == S_ENQ);
            dequeue_out <= (w_state_next == S_DEQ);
            reject_out  <= w_reject;
            full_out    <= w_full;
            empty_out   <= w_empty;
        end
    end

endmodule

`default_nettype wire
